// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and byte/word helpers.
// The S-box and rcon tables arrive as flat buses so callers can supply their own.
package aes_pkg;

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned SBOX_W = 2048;
  localparam int unsigned RCON_W = 120;
  localparam int unsigned RND_W  = 4;

  typedef enum logic [1:0] {IDLE, FWD, EMIT} state_e;

  // Entry x sits at [SBOX_W-1-8x -: 8]; shifting left by 8x brings it to the top byte.
  function automatic logic [7:0] sbox_lookup(input logic [SBOX_W-1:0] sbox,
                                             input logic [7:0]        b);
    logic [SBOX_W-1:0] sh;
    sh = sbox << {b, 3'b000};
    return sh[SBOX_W-1 -: 8];
  endfunction

  // Round r (1..15) sits in byte r-1 counted from the top; round 0 has no constant.
  function automatic logic [7:0] rcon_byte(input logic [RCON_W-1:0] rcon,
                                           input logic [RND_W-1:0]  r);
    logic [RCON_W-1:0] sh;
    logic [7:0]        res;
    if (r == '0) begin
      res = 8'h00;
    end else begin
      sh  = rcon << {(r - RND_W'(1)), 3'b000};
      res = sh[RCON_W-1 -: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [SBOX_W-1:0] sbox,
                                               input logic [31:0]       w);
    logic [31:0] rot;
    rot = {w[23:0], w[31:24]};
    return {sbox_lookup(sbox, rot[31:24]), sbox_lookup(sbox, rot[23:16]),
            sbox_lookup(sbox, rot[15:8]),  sbox_lookup(sbox, rot[7:0])};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (dir=0) or inverse (dir=1).
// Both directions share a single SubWord(RotWord()) path through the S-box.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [KEY_W-1:0]  key,
  input  logic [RND_W-1:0]  round,
  input  logic [SBOX_W-1:0] sbox,
  input  logic [RCON_W-1:0] rcon,
  input  logic              dir,
  output logic [KEY_W-1:0]  key_next
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t_in, t_out, rc_word;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  // Inverse step recovers the previous w3 first, which is what fed T() going forward.
  assign t_in    = dir ? (w3 ^ w2) : w3;
  assign t_out   = sub_rot_word(sbox, t_in);
  assign rc_word = {rcon_byte(rcon, round), 24'h00_0000};

  always_comb begin
    n0 = '0;
    n1 = '0;
    n2 = '0;
    n3 = '0;
    if (!dir) begin
      n0 = w0 ^ t_out ^ rc_word;
      n1 = w1 ^ n0;
      n2 = w2 ^ n1;
      n3 = w3 ^ n2;
    end else begin
      n3 = w3 ^ w2;
      n2 = w2 ^ w1;
      n1 = w1 ^ w0;
      n0 = w0 ^ t_out ^ rc_word;
    end
    key_next = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_key_unroll.sv
// Streams AES-128 round keys in decryption order (round NROUNDS down to 0).
// Runs the schedule forward once, then walks it back one key per handshake.
module aes_key_unroll
  import aes_pkg::*;
#(
  parameter int unsigned NROUNDS = 10,
  parameter int unsigned IDXW    = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              validIn,
  output logic              readyOut,
  input  logic [KEY_W-1:0]  keyIn,
  input  logic [SBOX_W-1:0] sbox,
  input  logic [RCON_W-1:0] rcon,
  input  logic              flush,
  output logic              keyValid,
  input  logic              keyReady,
  output logic [KEY_W-1:0]  keyOut,
  output logic [IDXW-1:0]   keyIdx,
  output logic              keyLast
);

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  // Round counter during FWD, doubles as the emitted key index during EMIT.
  logic [IDXW-1:0]    cnt_q, cnt_d;
  logic [RND_W-1:0]   step_round;
  logic               step_dir;
  logic [KEY_W-1:0]   step_key;

  assign step_round = RND_W'(cnt_q);
  assign step_dir   = (state_q == EMIT);

  aes_key_step u_step (
    .key      (key_q),
    .round    (step_round),
    .sbox     (sbox),
    .rcon     (rcon),
    .dir      (step_dir),
    .key_next (step_key)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (validIn) begin
          key_d   = keyIn;
          cnt_d   = IDXW'(1);
          state_d = FWD;
        end
      end
      FWD: begin
        key_d = step_key;
        if (cnt_q == IDXW'(NROUNDS)) begin
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q + IDXW'(1);
        end
      end
      EMIT: begin
        if (keyReady) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            key_d = step_key;
            cnt_d = cnt_q - IDXW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides any handshake in the same cycle.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  assign readyOut = (state_q == IDLE);
  assign keyValid = (state_q == EMIT);
  assign keyOut   = keyValid ? key_q : '0;
  assign keyIdx   = keyValid ? cnt_q : '0;
  assign keyLast  = keyValid && (cnt_q == '0);

endmodule

// File: tb/tb_aes_key_unroll.sv
// Directed bench for aes_key_unroll against FIPS-197 key-expansion vectors,
// with a second NROUNDS=1 instance for the single-round case.
module tb_aes_key_unroll;

  localparam logic [127:0] KEY0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEYX = 128'hdeadbeef0123456789abcdeffedcba98;

  logic           clk;
  logic           rstN;
  logic           validIn, readyOut, flush, keyValid, keyReady, keyLast;
  logic [127:0]   keyIn, keyOut;
  logic [3:0]     keyIdx;
  logic [2047:0]  sbox;
  logic [119:0]   rcon;

  logic           v1, r1, fl1, kv1, kr1, kl1;
  logic [127:0]   k1, ko1;
  logic [3:0]     ki1;

  logic [127:0]   rk [0:10];
  int             n_checks;
  int             n_pass;

  aes_key_unroll #(.NROUNDS(10), .IDXW(4)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .validIn  (validIn),
    .readyOut (readyOut),
    .keyIn    (keyIn),
    .sbox     (sbox),
    .rcon     (rcon),
    .flush    (flush),
    .keyValid (keyValid),
    .keyReady (keyReady),
    .keyOut   (keyOut),
    .keyIdx   (keyIdx),
    .keyLast  (keyLast)
  );

  aes_key_unroll #(.NROUNDS(1), .IDXW(4)) dut1 (
    .clk      (clk),
    .rstN     (rstN),
    .validIn  (v1),
    .readyOut (r1),
    .keyIn    (k1),
    .sbox     (sbox),
    .rcon     (rcon),
    .flush    (fl1),
    .keyValid (kv1),
    .keyReady (kr1),
    .keyOut   (ko1),
    .keyIdx   (ki1),
    .keyLast  (kl1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a key for one edge and wait (bounded) for the first keyValid.
  task automatic start(input logic [127:0] k, input int lat, input bit poke);
    int n;
    validIn = 1'b1;
    keyIn   = k;
    tick();
    validIn = 1'b0;
    n = 0;
    while (!keyValid && n < 50) begin
      check("fwd_ready_low", 128'(readyOut), 128'(0));
      if (poke) begin
        validIn = 1'($urandom_range(1));
        keyIn   = KEYX;
      end
      tick();
      n++;
    end
    validIn = 1'b0;
    check("latency", 128'(n), 128'(lat));
  endtask

  // Consume all 11 keys, keyReady high duty% of cycles; checks every sampled cycle.
  task automatic drain(input int unsigned duty, input bit poke);
    int e;
    int budget;
    bit hs;
    e = 10;
    budget = 400;
    while (e >= 0 && budget > 0) begin
      check("valid_held", 128'(keyValid), 128'(1));
      check("idx", 128'(keyIdx), 128'(e));
      check("key", keyOut, rk[e]);
      check("last", 128'(keyLast), 128'(e == 0));
      keyReady = ($urandom_range(99) < duty);
      if (poke) begin
        validIn = 1'($urandom_range(1));
        keyIn   = KEYX;
      end
      hs = keyReady;
      tick();
      if (hs) e--;
      budget--;
    end
    keyReady = 1'b0;
    validIn  = 1'b0;
    check("drain_done", 128'(e), 128'(-1));
    check("post_ready", 128'(readyOut), 128'(1));
    check("post_valid", 128'(keyValid), 128'(0));
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_pass   = 0;
    rk[0]  = KEY0;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    sbox = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    rcon = 120'h01020408102040801b366cd8ab4d9a;
    rstN = 1'b0; validIn = 1'b0; keyIn = '0; keyReady = 1'b0; flush = 1'b0;
    v1 = 1'b0; k1 = '0; kr1 = 1'b0; fl1 = 1'b0;

    repeat (2) tick();
    check("rst_ready", 128'(readyOut), 128'(1));
    check("rst_valid", 128'(keyValid), 128'(0));
    check("rst_key", keyOut, 128'(0));
    check("rst_idx", 128'(keyIdx), 128'(0));
    check("rst_last", 128'(keyLast), 128'(0));
    rstN = 1'b1;
    tick();

    // Full sequence with keyReady tied high, then back-to-back second key under stalls.
    start(KEY0, 10, 1'b0);
    drain(100, 1'b0);
    start(KEY0, 10, 1'b0);
    drain(30, 1'b0);

    // Foreign key pulsed on validIn during FWD and EMIT must be ignored.
    start(KEY0, 10, 1'b1);
    drain(50, 1'b1);

    // Flush at idx 6 racing a handshake.
    start(KEY0, 10, 1'b0);
    keyReady = 1'b1;
    n = 0;
    while (keyIdx != 4'd6 && n < 20) begin
      tick();
      n++;
    end
    check("flush_reach", 128'(keyIdx), 128'(6));
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    keyReady = 1'b0;
    check("flush_valid", 128'(keyValid), 128'(0));
    check("flush_ready", 128'(readyOut), 128'(1));
    check("flush_idx", 128'(keyIdx), 128'(0));
    start(128'h0, 10, 1'b0);
    check("zero_idx", 128'(keyIdx), 128'(10));
    check("zero_key", keyOut, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush2_ready", 128'(readyOut), 128'(1));

    // Async reset in the middle of the forward pass.
    validIn = 1'b1;
    keyIn   = KEY0;
    tick();
    validIn = 1'b0;
    repeat (4) tick();
    check("midfwd_busy", 128'(readyOut), 128'(0));
    #2 rstN = 1'b0;
    #1;
    check("arst_ready", 128'(readyOut), 128'(1));
    check("arst_valid", 128'(keyValid), 128'(0));
    check("arst_key", keyOut, 128'(0));
    check("arst_idx", 128'(keyIdx), 128'(0));
    check("arst_last", 128'(keyLast), 128'(0));
    #2 rstN = 1'b1;
    n = 0;
    repeat (12) begin
      tick();
      if (keyValid) n++;
    end
    check("arst_no_emit", 128'(n), 128'(0));
    start(KEY0, 10, 1'b0);
    drain(100, 1'b0);

    // Single-round instance.
    v1 = 1'b1;
    k1 = KEY0;
    tick();
    v1 = 1'b0;
    check("r1_busy", 128'(r1), 128'(0));
    tick();
    check("r1_valid", 128'(kv1), 128'(1));
    check("r1_idx1", 128'(ki1), 128'(1));
    check("r1_key1", ko1, rk[1]);
    check("r1_last1", 128'(kl1), 128'(0));
    kr1 = 1'b1;
    tick();
    check("r1_idx0", 128'(ki1), 128'(0));
    check("r1_key0", ko1, KEY0);
    check("r1_last0", 128'(kl1), 128'(1));
    tick();
    kr1 = 1'b0;
    check("r1_ready", 128'(r1), 128'(1));
    check("r1_done", 128'(kv1), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
